// File: rtl/rle2_pkg.sv
//------------------------------------------------------------------------------
// Module   : rle2_pkg
// Brief    : Shared defaults, pair type and drain-state encoding for RLE2.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rle2_pkg;

    localparam int CNT_W_DEF      = 16;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int HDR_FLAG       = 31;

    // Count is held at full header-field width so one pair type serves any CNT_W <= 31.
    typedef struct packed {
        logic [30:0] count;
        logic [31:0] value;
    } pair_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        VAL  = 2'd2
    } drain_state_e;

    function automatic logic [31:0] hdr_word(input logic [30:0] count);
        logic [31:0] w;
        w           = {1'b0, count};
        w[HDR_FLAG] = 1'b1;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rle2_fifo.sv
//------------------------------------------------------------------------------
// Module   : rle2_fifo
// Brief    : Synchronous (count, value) pair FIFO; a same-edge pop frees room for a push.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rle2_fifo
    import rle2_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic  clock,
    input  logic  sysres,
    input  logic  push_i,
    input  pair_t din_i,
    input  logic  pop_i,
    output pair_t dout_o,
    output logic  empty_o,
    output logic  full_o
);

    localparam int AW = $clog2(DEPTH);

    pair_t          mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    cnt_q;
    logic           do_pop;
    logic           do_push;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clock or negedge sysres) begin
        if (!sysres) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

`default_nettype wire

// File: rtl/rle2.sv
//------------------------------------------------------------------------------
// Module   : rle2
// Brief    : Run-length encoder emitting header/value word pairs from a pair FIFO.
//            Define RLE2_ZERO_IDLE_EN to drive outdata to zero while idle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rle2
    import rle2_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clock,
    input  logic        sysres,
    input  logic [31:0] datain,
    output logic [31:0] outdata,
    output logic        outvalid,
    output logic        ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             run_open_q, run_open_d;
    logic [31:0]      cur_val_q,  cur_val_d;
    logic [CNT_W-1:0] cur_cnt_q,  cur_cnt_d;
    logic             ovf_q,      ovf_d;
    logic             push;
    pair_t            push_pair;

    drain_state_e     state_q, state_d;
    logic [31:0]      outdata_q, outdata_d;
    logic             outvalid_q, outvalid_d;
    logic [31:0]      hold_q;
    logic             pop;
    pair_t            head;
    logic             fifo_empty;
    logic             fifo_full;

    rle2_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .sysres  (sysres),
        .push_i  (push),
        .din_i   (push_pair),
        .pop_i   (pop),
        .dout_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        run_open_d      = 1'b1;
        cur_val_d       = datain;
        cur_cnt_d       = CNT_W'(1);
        push            = 1'b0;
        push_pair.count = 31'(cur_cnt_q);
        push_pair.value = cur_val_q;
        if (run_open_q && (datain == cur_val_q) && (cur_cnt_q != CNT_MAX)) begin
            cur_cnt_d = cur_cnt_q + CNT_W'(1);
        end else if (run_open_q) begin
            push = 1'b1;
        end
        // A pop on this edge frees a slot, so only a full FIFO without a pop drops.
        ovf_d = ovf_q | (push & fifo_full & ~pop);
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        outvalid_d = 1'b0;
`ifdef RLE2_ZERO_IDLE_EN
        outdata_d  = '0;
`else
        outdata_d  = outdata_q;
`endif
        case (state_q)
            HDR: begin
                state_d    = VAL;
                outvalid_d = 1'b1;
                outdata_d  = hold_q;
            end
            default: begin
                if (!fifo_empty) begin
                    state_d    = HDR;
                    pop        = 1'b1;
                    outvalid_d = 1'b1;
                    outdata_d  = hdr_word(head.count);
                end else begin
                    state_d    = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge sysres) begin
        if (!sysres) begin
            run_open_q <= 1'b0;
            cur_val_q  <= '0;
            cur_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
            outdata_q  <= '0;
            outvalid_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            run_open_q <= run_open_d;
            cur_val_q  <= cur_val_d;
            cur_cnt_q  <= cur_cnt_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            outdata_q  <= outdata_d;
            outvalid_q <= outvalid_d;
            if (pop) hold_q <= head.value;
        end
    end

    assign outdata  = outdata_q;
    assign outvalid = outvalid_q;
    assign ovf      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_rle2.sv
//------------------------------------------------------------------------------
// Module   : tb_rle2
// Brief    : Scoreboard bench for rle2 (default, CNT_W=4 and FIFO_DEPTH=2 instances).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rle2;

    logic        clock;
    logic        sysres;
    logic [31:0] datain;
    logic [31:0] od [3];
    logic        ov [3];
    logic        of_ [3];

    int checks;
    int passes;

    rle2 u0 (.clock(clock), .sysres(sysres), .datain(datain),
             .outdata(od[0]), .outvalid(ov[0]), .ovf(of_[0]));
    rle2 #(.CNT_W(4)) u1 (.clock(clock), .sysres(sysres), .datain(datain),
             .outdata(od[1]), .outvalid(ov[1]), .ovf(of_[1]));
    rle2 #(.FIFO_DEPTH(2)) u2 (.clock(clock), .sysres(sysres), .datain(datain),
             .outdata(od[2]), .outvalid(ov[2]), .ovf(of_[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: runs, a pending-pair list per instance, and a drain that
    // takes one pair every two cycles at most.
    int unsigned mx [3] = '{65535, 15, 65535};
    int          dp [3] = '{8, 8, 2};
    logic        m_open [3];
    logic [31:0] m_val [3];
    int unsigned m_cnt [3];
    logic        m_ovf [3];
    int          free_at [3];
    int          cyc;
    logic [63:0] fq [3][$];
    logic [31:0] eq [3][$];
    logic [31:0] last [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    always @(posedge clock or negedge sysres) begin
        if (!sysres) begin
            cyc = 0;
            for (int k = 0; k < 3; k++) begin
                m_open[k]  = 1'b0;
                m_val[k]   = '0;
                m_cnt[k]   = 0;
                m_ovf[k]   = 1'b0;
                free_at[k] = 0;
                fq[k].delete();
                eq[k].delete();
            end
        end else begin
            cyc++;
            for (int k = 0; k < 3; k++) begin
                logic [63:0] p;
                logic        popped;
                popped = 1'b0;
                if (cyc >= free_at[k] && fq[k].size() > 0) begin
                    p = fq[k].pop_front();
                    eq[k].push_back(32'h8000_0000 | p[63:32]);
                    eq[k].push_back(p[31:0]);
                    free_at[k] = cyc + 2;
                    popped = 1'b1;
                end
                if (!m_open[k]) begin
                    m_open[k] = 1'b1;
                    m_val[k]  = datain;
                    m_cnt[k]  = 1;
                end else if (datain == m_val[k] && m_cnt[k] < mx[k]) begin
                    m_cnt[k] = m_cnt[k] + 1;
                end else begin
                    if (fq[k].size() < dp[k]) fq[k].push_back({m_cnt[k], m_val[k]});
                    else m_ovf[k] = 1'b1;
                    m_val[k] = datain;
                    m_cnt[k] = 1;
                end
                if (popped && fq[k].size() > dp[k]) m_ovf[k] = 1'bx;
            end
        end
    end

    // Monitor: every valid word must be the next expected one.
    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (!sysres) begin
                last[k] = '0;
            end else begin
                chk($sformatf("ovf[%0d]", k), {31'b0, of_[k]}, {31'b0, m_ovf[k]});
                if (ov[k]) begin
                    if (eq[k].size() == 0) begin
                        chk($sformatf("unexpected_word[%0d]", k), od[k], 32'hxxxx_xxxx);
                    end else begin
                        chk($sformatf("stream[%0d]", k), od[k], eq[k].pop_front());
                    end
                    last[k] = od[k];
                end else begin
`ifdef RLE2_ZERO_IDLE_EN
                    chk($sformatf("idle_zero[%0d]", k), od[k], 32'h0);
`else
                    chk($sformatf("idle_hold[%0d]", k), od[k], last[k]);
`endif
                end
            end
        end
    end

    task automatic drive(input logic [31:0] v);
        datain = v;
        @(negedge clock);
    endtask

    task automatic reset_checks(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_outdata[%0d]", tag, k), od[k], 32'h0);
            chk($sformatf("%s_outvalid[%0d]", tag, k), {31'b0, ov[k]}, 32'h0);
            chk($sformatf("%s_ovf[%0d]", tag, k), {31'b0, of_[k]}, 32'h0);
        end
    endtask

    initial begin
        logic found;
        logic [31:0] v;
        int unsigned len;
        checks = 0;
        passes = 0;
        sysres = 1'b0;
        datain = '0;
        repeat (3) @(negedge clock);
        reset_checks("por");
        sysres = 1'b1;

        drive(32'h0);
        repeat (5) drive(32'hDEAD_BEEF);
        repeat (3) drive(32'hFFFF_FFFF);
        repeat (4) drive(32'hCCCC_CCCC);
        drive(32'hA0A0_A0A0);
        drive(32'hFFFF_FFFF);

        repeat (20) drive(32'h1234_5678);
        drive(32'h0);
        repeat (6) drive(32'h0);

        for (int i = 0; i < 10; i++) drive((i % 2 == 0) ? 32'h1 : 32'h2);
        repeat (30) drive(32'h9);

        // Reset while a run is open.
        #2 sysres = 1'b0;
        #1 reset_checks("rst_run");
        repeat (2) @(negedge clock);
        sysres = 1'b1;
        repeat (3) drive(32'h11);

        // Reset between a header and its value word.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            drive(32'h22);
            if (ov[0] && od[0][31]) found = 1'b1;
        end
        chk("header_seen_before_timeout", {31'b0, found}, 32'h1);
        #1 sysres = 1'b0;
        #1 reset_checks("rst_pair");
        repeat (2) @(negedge clock);
        sysres = 1'b1;
        repeat (2) drive(32'h33);
        repeat (3) drive(32'h44);

        for (int r = 0; r < 60; r++) begin
            case ($urandom_range(0, 3))
                0:       v = 32'h0;
                1:       v = 32'h5;
                2:       v = 32'hFFFF_FFFF;
                default: v = $urandom;
            endcase
            len = ($urandom_range(0, 9) == 0) ? 18 : $urandom_range(1, 4);
            repeat (len) drive(v);
        end
        drive(32'h7777_7777);
        repeat (40) drive(32'h7777_7777);

        for (int k = 0; k < 3; k++)
            chk($sformatf("pending_words[%0d]", k), eq[k].size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rle2.md
RLE2 -- requirements
Module: rle2

Interface
REQ-001 Parameter CNT_W, default 16: run-count width; also the maximum run length, 2^CNT_W-1.
REQ-002 Parameter FIFO_DEPTH, default 8: number of pending (count, value) pairs; must be a power of 2.
REQ-003 clock  input  1: single clock; all state changes on the rising edge.
REQ-004 sysres  input  1: reset, asynchronous assert, active-low.
REQ-005 datain  input  32: raw word, sampled on every rising edge outside reset.
REQ-006 outdata  output  32: encoded stream word (header or value).
REQ-007 outvalid  output  1: outdata carries a stream word this cycle; placed after outdata in port order.
REQ-008 ovf  output  1: sticky flag, set when a pair is dropped.

Function
REQ-009 Run tracking: state is run_open, cur_val[31:0] and cur_cnt[CNT_W-1:0]; the first sampled word after reset opens a run with cur_cnt=1.
REQ-010 When datain==cur_val and cur_cnt<max, the sample increments cur_cnt by 1.
REQ-011 A run closes on a sample that differs from cur_val, or on a sample equal to cur_val while cur_cnt==max.
  - On close: push the pair (cur_cnt, cur_val) to the FIFO.
  - On the same edge: open a new run with the sample and cur_cnt=1.
REQ-012 Header word = {1'b1, (31-CNT_W) zero bits, count}; value word = cur_val verbatim.
REQ-013 Drain sequencing:
  - Each pair is emitted as its header on one cycle, then its value word on the next cycle, with outvalid=1 on both.
  - A pair is never split or interleaved with another pair.
  - After reset the stream strictly alternates header, value.
REQ-014 Latency: a header appears on the rising edge after its closing edge when the FIFO is empty and the drain is idle; otherwise it follows the prior pair with no gap.
REQ-015 outvalid=0 whenever no pair is being drained.
REQ-016 FIFO full at a close event:
  - The new pair is dropped and ovf is set to 1.
  - ovf holds until reset.
  - The new run opens normally.
REQ-017 Push and pop on the same edge while the FIFO is full: the pop frees the slot first, so the push succeeds and ovf is not set.
REQ-018 An open run is never flushed: it is emitted only when it closes.

Reset
REQ-019 sysres low, effective immediately:
  - outdata=0, outvalid=0, ovf=0.
  - run_open=0, cur_cnt=0, cur_val=0.
  - FIFO emptied and drain reset to idle.
REQ-020 Reset mid-run or mid-pair discards the open run, all queued pairs and any half-emitted pair.
REQ-021 The first sample after reset deasserts opens a fresh run.

Configuration
REQ-022 Macro RLE2_ZERO_IDLE_EN.
  - Defined: outdata is forced to 32'h0 on every cycle with outvalid=0.
  - Undefined: outdata holds the last emitted word while outvalid=0.

Structure
REQ-023 Shared package rle2_pkg holds:
  - CNT_W and FIFO_DEPTH defaults.
  - HDR_FLAG bit position (31).
  - The pair typedef {count, value}.
  - The drain-state enum {IDLE, HDR, VAL}.
REQ-024 Sub-module rle2_fifo: synchronous pair FIFO with wrap-around pointers, full/empty flags and the simultaneous push/pop rule of REQ-017.
REQ-025 Top-level rle2 contains the run tracker and the drain FSM:
  - IDLE goes to HDR when the FIFO is not empty.
  - HDR always goes to VAL.
  - VAL goes to HDR if the FIFO is not empty, else to IDLE.

Verification
REQ-026 Reset with datain=0, release, one sample of 0, then 5x DEADBEEF, then FFFFFFFF -> emitted pairs 0x80000001/0x00000000, then 0x80000005/0xDEADBEEF.
REQ-027 3x FFFFFFFF, 4x CCCCCCCC, 1x A0A0A0A0, then FFFFFFFF -> pairs 0x80000003/FFFFFFFF, 0x80000004/CCCCCCCC, 0x80000001/A0A0A0A0, with the header/value alternation preserved.
REQ-028 CNT_W=4, 20x 12345678, then 0 -> pairs 0x8000000F/12345678, then 0x80000005/12345678.
REQ-029 FIFO_DEPTH=2, alternating 1,2,1,2,... for 10 cycles -> ovf rises once the FIFO fills, dropped pairs never appear, and the emitted stream stays well-framed.
REQ-030 Assert sysres low mid-run and again between a header and its value word -> all outputs are 0 immediately, no value word follows the orphaned header, and the first pair after release is the new data.
REQ-031 Build with and without RLE2_ZERO_IDLE_EN -> during outvalid=0, outdata is 0 (with the macro) or holds the last word (without the macro).
